pe_array_feeder: RTL and testbench
==================================

Name: pe_array_feeder

Overview:
- Sequencer that drives the 5x5 processing-element array.
- Loads one 5x5 kernel from weight memory into the five PE rows.
- Then walks every valid output position of a feature map, streams each 5x5 window into the PEs, and captures the summed 32-bit array result as one output pixel.
- Sits between the feature/weight buffers and the PE array. It is the write-side master of the array's IF_w/W_w/IF_in/W_in interface and the consumer of its Result.

Parameters:
- IMG_W, 32, feature-map width in pixels
- IMG_H, 32, feature-map height in pixels
- K, 5, kernel size; fixed by the array, only 5 supported
- FADDR_W, 10, feature-memory address width; must satisfy 2^FADDR_W >= IMG_W*IMG_H
- WADDR_W, 5, weight-memory address width; must satisfy 2^WADDR_W >= K*K

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a job when idle
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last output is accepted
- w_addr  out  WADDR_W  weight-memory read address
- w_rdata  in  8  weight data, valid 1 cycle after w_addr
- f_addr  out  FADDR_W  feature-memory read address
- f_rdata  in  8  feature data, valid 1 cycle after f_addr
- pe_w_w  out  5  per-row weight write strobe; bit r drives PE row r+1
- pe_if_w  out  5  per-row feature write strobe
- w_out  out  8  shared weight bus to the array
- if_out  out  8  shared feature bus to the array
- pe_result  in  32  summed array result; combinational from PE state
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accept
- out_data  out  32  output pixel value
- out_x, out_y  out  FADDR_W each  output coordinates of out_data

Behaviour:
- Reset (async, rst=0): every output is 0. FSM goes to IDLE. All counters are cleared.
- Array contract: each PE row is a 5-deep shift register for W and a 5-deep shift register for IF. A row shifts in its bus byte on any cycle its strobe is high. pe_result is the sum of the 25 products and is valid the cycle after the last write.
- At most one bit of pe_w_w and pe_if_w combined is high in any cycle.
- FSM states:
  - IDLE: start=1 -> LOAD_W and busy=1. Otherwise no change.
  - LOAD_W: issues w_addr = r*5+c for r,c = 0..4, c fastest, 25 addresses on consecutive cycles. One cycle later, w_out = w_rdata and pe_w_w = onehot(r) for the matching address (1-cycle pipelined strobe). After the last strobe -> LOAD_IF with ox=oy=0.
  - LOAD_IF: issues f_addr = (oy+r)*IMG_W + (ox+c), same r/c order. One cycle later, if_out = f_rdata and pe_if_w = onehot(r). After the 25th strobe -> SETTLE.
  - SETTLE: 1 cycle. Latch pe_result into out_data and ox/oy into out_x/out_y. Then -> OUT with out_valid=1.
  - OUT: out_data, out_x and out_y are held while out_ready=0. On out_valid&&out_ready, advance ox; ox wraps at IMG_W-K to 0 and increments oy. The last position (ox=IMG_W-K, oy=IMG_H-K) -> DONE; otherwise -> LOAD_IF.
  - DONE: done=1 for 1 cycle, busy=0 -> IDLE.
- Latency: 25+1 cycles to load weights. Each output takes 25 load + 1 pipeline + 1 settle = 27 cycles to out_valid, plus stall cycles.
- Output count per job: (IMG_W-K+1)*(IMG_H-K+1); 784 for the defaults.
- A start pulse while busy is ignored.
- out_ready high while out_valid=0 has no effect. out_valid may stay high indefinitely; the FSM waits.
- Reset mid-job: strobes drop immediately (async). No done pulse is issued. The next start reloads the weights.
- Address arithmetic is unsigned with no overflow, guaranteed by the parameter constraints.

Decomposition:
- Shared package pe_pkg:
  - K=5 and PE_ROWS=5
  - data width 8 and result width 32
  - FSM state enum {IDLE, LOAD_W, LOAD_IF, SETTLE, OUT, DONE}
- One natural sub-module, win_addr_gen: holds the r/c/ox/oy counters and produces f_addr/w_addr, last_tap and last_window flags. The FSM and strobe pipeline stay in pe_array_feeder.

Test Plan:
- Weights 0..24, feature pixel = 1 everywhere, IMG 8x8 -> 16 outputs, each out_data=300. done pulses once; busy is high throughout.
- Weights all 1, feature(x,y) = x+y, IMG 8x8 -> out(0,0)=100, out(3,3)=250, out_x/out_y in raster order.
- Strobe check -> during LOAD_W the pe_w_w sequence is exactly 5x 00001, 5x 00010, … , 5x 10000. The same holds for pe_if_w. Strobes and w_out/if_out are aligned 1 cycle after the address.
- out_ready held low 10 cycles at output 3 -> out_data/out_x/out_y stable. No f_addr activity or strobes while stalled. Resumes correctly after ready.
- start pulsed again mid-job -> ignored. Output count is still 16 and done pulses once.
- rst asserted during LOAD_IF of output 5 -> all outputs 0 immediately. A new start yields a full 16-output job with correct values.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and constants for the 5x5 PE array feeder.
// Sizes, FSM states and the row strobe helper.
package pe_pkg;

   localparam int K       = 5;
   localparam int PE_ROWS = 5;
   localparam int DATA_W  = 8;
   localparam int RES_W   = 32;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      LOAD_IF,
      SETTLE,
      OUT,
      DONE
   } state_t;

   function automatic logic [PE_ROWS-1:0] row_onehot(input logic [2:0] row);
      return PE_ROWS'(1) << row;
   endfunction

endpackage

// File: rtl/win_addr_gen.sv
// Tap (r/c) and window (ox/oy) counters for the PE feeder.
// Produces weight and feature read addresses plus end flags.
module win_addr_gen
   import pe_pkg::*;
#(
   parameter int IMG_W   = 32,
   parameter int IMG_H   = 32,
   parameter int K       = pe_pkg::K,
   parameter int FADDR_W = 10,
   parameter int WADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               tap_step,
   input  logic               win_step,
   output logic [2:0]         row,
   output logic [WADDR_W-1:0] w_addr,
   output logic [FADDR_W-1:0] f_addr,
   output logic [FADDR_W-1:0] ox,
   output logic [FADDR_W-1:0] oy,
   output logic               last_tap,
   output logic               last_window
);

   localparam logic [2:0]         KM1    = 3'(K - 1);
   localparam logic [FADDR_W-1:0] OX_MAX = FADDR_W'(IMG_W - K);
   localparam logic [FADDR_W-1:0] OY_MAX = FADDR_W'(IMG_H - K);

   logic [2:0]         r_q;
   logic [2:0]         c_q;
   logic [FADDR_W-1:0] ox_q;
   logic [FADDR_W-1:0] oy_q;

   // Tap counter (c fastest) and raster window counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_q  <= '0;
         c_q  <= '0;
         ox_q <= '0;
         oy_q <= '0;
      end else if (clr) begin
         r_q  <= '0;
         c_q  <= '0;
         ox_q <= '0;
         oy_q <= '0;
      end else begin
         if (tap_step) begin
            if (c_q == KM1) begin
               c_q <= '0;
               r_q <= (r_q == KM1) ? 3'd0 : r_q + 3'd1;
            end else begin
               c_q <= c_q + 3'd1;
            end
         end
         if (win_step) begin
            if (ox_q == OX_MAX) begin
               ox_q <= '0;
               oy_q <= (oy_q == OY_MAX) ? '0 : oy_q + 1'b1;
            end else begin
               ox_q <= ox_q + 1'b1;
            end
         end
      end
   end

   assign row         = r_q;
   assign ox          = ox_q;
   assign oy          = oy_q;
   assign last_tap    = (r_q == KM1) && (c_q == KM1);
   assign last_window = (ox_q == OX_MAX) && (oy_q == OY_MAX);

   assign w_addr = WADDR_W'(r_q) * WADDR_W'(K) + WADDR_W'(c_q);
   assign f_addr = (oy_q + FADDR_W'(r_q)) * FADDR_W'(IMG_W)
                 + ox_q + FADDR_W'(c_q);

endmodule

// File: rtl/pe_array_feeder.sv
// Sequencer feeding a 5x5 PE array: kernel load, then one
// 5x5 window per output pixel with valid/ready output.
module pe_array_feeder
   import pe_pkg::*;
#(
   parameter int IMG_W   = 32,
   parameter int IMG_H   = 32,
   parameter int K       = pe_pkg::K,
   parameter int FADDR_W = 10,
   parameter int WADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic [WADDR_W-1:0] w_addr,
   input  logic [DATA_W-1:0]  w_rdata,
   output logic [FADDR_W-1:0] f_addr,
   input  logic [DATA_W-1:0]  f_rdata,
   output logic [PE_ROWS-1:0] pe_w_w,
   output logic [PE_ROWS-1:0] pe_if_w,
   output logic [DATA_W-1:0]  w_out,
   output logic [DATA_W-1:0]  if_out,
   input  logic [RES_W-1:0]   pe_result,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [RES_W-1:0]   out_data,
   output logic [FADDR_W-1:0] out_x,
   output logic [FADDR_W-1:0] out_y
);

   state_t             state;
   logic               drain;
   logic [2:0]         row;
   logic [FADDR_W-1:0] ox;
   logic [FADDR_W-1:0] oy;
   logic               last_tap;
   logic               last_window;
   logic               clr;
   logic               tap_step;
   logic               win_step;

   // Counter control: taps advance while issuing, windows on accept.
   always_comb begin
      clr      = (state == IDLE) && start;
      tap_step = ((state == LOAD_W) || (state == LOAD_IF)) && !drain;
      win_step = (state == OUT) && out_ready;
   end

   win_addr_gen #(
      .IMG_W   (IMG_W),
      .IMG_H   (IMG_H),
      .K       (K),
      .FADDR_W (FADDR_W),
      .WADDR_W (WADDR_W)
   ) u_addr (
      .clk         (clk),
      .rst         (rst),
      .clr         (clr),
      .tap_step    (tap_step),
      .win_step    (win_step),
      .row         (row),
      .w_addr      (w_addr),
      .f_addr      (f_addr),
      .ox          (ox),
      .oy          (oy),
      .last_tap    (last_tap),
      .last_window (last_window)
   );

   // Memory data lands one cycle after the address, aligned with the strobe.
   always_comb begin
      w_out  = (|pe_w_w)  ? w_rdata : '0;
      if_out = (|pe_if_w) ? f_rdata : '0;
   end

   // Main sequencer; drain is the extra cycle for the last pipelined strobe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         drain     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pe_w_w    <= '0;
         pe_if_w   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_x     <= '0;
         out_y     <= '0;
      end else begin
         pe_w_w  <= '0;
         pe_if_w <= '0;
         done    <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state <= LOAD_W;
                  busy  <= 1'b1;
                  drain <= 1'b0;
               end
            end
            LOAD_W: begin
               if (drain) begin
                  drain <= 1'b0;
                  state <= LOAD_IF;
               end else begin
                  pe_w_w <= row_onehot(row);
                  drain  <= last_tap;
               end
            end
            LOAD_IF: begin
               if (drain) begin
                  drain <= 1'b0;
                  state <= SETTLE;
               end else begin
                  pe_if_w <= row_onehot(row);
                  drain   <= last_tap;
               end
            end
            SETTLE: begin
               out_data  <= pe_result;
               out_x     <= ox;
               out_y     <= oy;
               out_valid <= 1'b1;
               state     <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (last_window) begin
                     state <= DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     state <= LOAD_IF;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pe_array_feeder.sv
// Randomized bench for pe_array_feeder on an 8x8 image.
// Memories and PE array are modelled; outputs go to a reference queue.
module tb_pe_array_feeder;

   localparam int IW = 8;
   localparam int IH = 8;
   localparam int NOUT = (IW - 4) * (IH - 4);

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        busy;
   logic        done;
   logic [4:0]  w_addr;
   logic [7:0]  w_rdata = '0;
   logic [5:0]  f_addr;
   logic [7:0]  f_rdata = '0;
   logic [4:0]  pe_w_w;
   logic [4:0]  pe_if_w;
   logic [7:0]  w_out;
   logic [7:0]  if_out;
   logic [31:0] pe_result;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [5:0]  out_x;
   logic [5:0]  out_y;

   pe_array_feeder #(
      .IMG_W   (IW),
      .IMG_H   (IH),
      .K       (5),
      .FADDR_W (6),
      .WADDR_W (5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .w_addr    (w_addr),
      .w_rdata   (w_rdata),
      .f_addr    (f_addr),
      .f_rdata   (f_rdata),
      .pe_w_w    (pe_w_w),
      .pe_if_w   (pe_if_w),
      .w_out     (w_out),
      .if_out    (if_out),
      .pe_result (pe_result),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_x     (out_x),
      .out_y     (out_y)
   );

   always #5 clk = ~clk;

   logic [7:0]  wmem [25];
   logic [7:0]  fmem [IW*IH];
   logic [7:0]  wsr  [5][5];
   logic [7:0]  fsr  [5][5];
   logic [31:0] acc_sum;
   logic [31:0] obs  [IH][IW];

   int errors = 0;
   int checks = 0;

   // Synchronous-read memories.
   always @(posedge clk) begin
      w_rdata <= wmem[w_addr];
      f_rdata <= fmem[f_addr];
   end

   // PE array: per-row shift registers for weights and features.
   always @(posedge clk) begin
      for (int r = 0; r < 5; r++) begin
         if (pe_w_w[r]) begin
            for (int k = 4; k > 0; k--) wsr[r][k] <= wsr[r][k-1];
            wsr[r][0] <= w_out;
         end
         if (pe_if_w[r]) begin
            for (int k = 4; k > 0; k--) fsr[r][k] <= fsr[r][k-1];
            fsr[r][0] <= if_out;
         end
      end
   end

   // Array result is the sum of all 25 products.
   always_comb begin
      acc_sum = '0;
      for (int r = 0; r < 5; r++)
         for (int k = 0; k < 5; k++)
            acc_sum = acc_sum + 32'(wsr[r][k]) * 32'(fsr[r][k]);
      pe_result = acc_sum;
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_pix(input int x, input int y);
      logic [31:0] s = 0;
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            s += 32'(wmem[r*5+c]) * 32'(fmem[(y+r)*IW + x + c]);
      return s;
   endfunction

   task automatic check_zero(input string tag);
      check({tag, "_ctl"},
            {busy, done, out_valid, pe_w_w, pe_if_w, w_out, if_out},
            64'd0);
      check({tag, "_adr"}, {w_addr, f_addr, out_x, out_y}, 64'd0);
      check({tag, "_dat"}, out_data, 64'd0);
   endtask

   task automatic run_job(input int stall_at, input bit rnd_ready,
                          input int restart_at, input int reset_at);
      int xs[$];
      int ys[$];
      logic [31:0] ds[$];
      logic [4:0] wseq[$];
      logic [4:0] fseq[$];
      int cyc = 0;
      int acc = 0;
      int dones = 0;
      int busy_bad = 0;
      int hot_bad = 0;
      int first_lat = -1;
      int stall_n = 0;
      int stall_bad = 0;
      int seq_bad = 0;
      bit restarted = 0;
      logic [31:0] s_d;
      logic [5:0] s_x;
      logic [5:0] s_y;
      logic [5:0] s_f;
      for (int y = 0; y <= IH - 5; y++)
         for (int x = 0; x <= IW - 5; x++) begin
            xs.push_back(x);
            ys.push_back(y);
            ds.push_back(ref_pix(x, y));
         end
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (dones == 0 && cyc < 20000) begin
         if (pe_w_w != 0) wseq.push_back(pe_w_w);
         if (pe_if_w != 0 && fseq.size() < 25) fseq.push_back(pe_if_w);
         if ($countones({pe_w_w, pe_if_w}) > 1) hot_bad++;
         if (done) dones++;
         else if (!busy) busy_bad++;
         if (reset_at >= 0 && acc == reset_at && pe_if_w != 0) begin
            rst = 1'b0;
            #1;
            check_zero("rst_mid");
            repeat (3) @(negedge clk);
            check_zero("rst_hold");
            rst = 1'b1;
            out_ready = 1'b0;
            return;
         end
         if (acc == restart_at && !restarted) begin
            start = 1'b1;
            restarted = 1;
         end else begin
            start = 1'b0;
         end
         if (out_valid && first_lat < 0) first_lat = cyc;
         if (out_valid) begin
            if (acc == stall_at && stall_n < 10) begin
               if (stall_n == 0) begin
                  s_d = out_data;
                  s_x = out_x;
                  s_y = out_y;
                  s_f = f_addr;
               end else if (out_data !== s_d || out_x !== s_x ||
                            out_y !== s_y || f_addr !== s_f ||
                            pe_w_w != 0 || pe_if_w != 0) begin
                  stall_bad++;
               end
               out_ready = 1'b0;
               stall_n++;
            end else begin
               out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
               if (out_ready) begin
                  if (ds.size() == 0) begin
                     check("extra_out", 1, 0);
                  end else begin
                     check("out_data", out_data, ds.pop_front());
                     check("out_x", out_x, 64'(xs.pop_front()));
                     check("out_y", out_y, 64'(ys.pop_front()));
                  end
                  if (out_x < IW && out_y < IH) obs[out_y][out_x] = out_data;
                  acc++;
               end
            end
         end else begin
            out_ready = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         cyc++;
      end
      out_ready = 1'b0;
      start = 1'b0;
      check("done_seen", dones, 1);
      repeat (5) begin
         if (done) dones++;
         @(negedge clk);
      end
      check("done_once", dones, 1);
      check("out_count", acc, NOUT);
      check("busy_gaps", busy_bad, 0);
      check("onehot", hot_bad, 0);
      check("first_lat", first_lat, 54);
      check("busy_after", busy, 0);
      check("w_strb_n", wseq.size(), 25);
      check("if_strb_n", fseq.size(), 25);
      for (int i = 0; i < 25 && i < wseq.size(); i++)
         if (wseq[i] != 5'(1 << (i / 5))) seq_bad++;
      for (int i = 0; i < 25 && i < fseq.size(); i++)
         if (fseq[i] != 5'(1 << (i / 5))) seq_bad++;
      check("strb_seq", seq_bad, 0);
      if (stall_at >= 0) begin
         check("stall_len", stall_n, 10);
         check("stall_stable", stall_bad, 0);
      end
   endtask

   // Strobe alignment: each strobe carries data for the previous address.
   int   last_wa = 0;
   int   last_fa = 0;
   int   algn_bad = 0;
   always @(negedge clk) begin
      if (pe_w_w != 0)
         if (pe_w_w != 5'(1 << (last_wa / 5)) || w_out !== wmem[last_wa])
            algn_bad++;
      if (pe_if_w != 0)
         if (if_out !== fmem[last_fa]) algn_bad++;
      last_wa = int'(w_addr);
      last_fa = int'(f_addr);
   end

   initial begin
      for (int i = 0; i < 25; i++) wmem[i] = 8'(i);
      for (int i = 0; i < IW*IH; i++) fmem[i] = 8'd1;
      #12;
      check_zero("reset");
      @(negedge clk);
      rst = 1'b1;

      run_job(-1, 0, -1, -1);
      check("t1_pix", obs[2][1], 300);

      for (int i = 0; i < 25; i++) wmem[i] = 8'd1;
      for (int y = 0; y < IH; y++)
         for (int x = 0; x < IW; x++) fmem[y*IW+x] = 8'(x + y);
      run_job(-1, 0, -1, -1);
      check("t2_pix00", obs[0][0], 100);
      check("t2_pix33", obs[3][3], 250);

      for (int i = 0; i < 25; i++) wmem[i] = 8'($urandom);
      for (int i = 0; i < IW*IH; i++) fmem[i] = 8'($urandom);
      run_job(3, 1, 2, -1);

      for (int i = 0; i < 25; i++) wmem[i] = 8'($urandom);
      for (int i = 0; i < IW*IH; i++) fmem[i] = 8'($urandom);
      run_job(-1, 1, -1, 5);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 25; i++) wmem[i] = 8'($urandom);
      run_job(-1, 1, -1, -1);

      check("align", algn_bad, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
